// File: rtl/snn_spike_collector.sv
// snn_spike_collector: per-core spike FIFOs drained round-robin into one {core_id, packet} valid/ready stream.
// Optional macro SPIKE_COLLECTOR_DROP_CNT_EN adds saturating per-channel drop counters and the drop_cnt port.
module snn_spike_collector #(
  parameter int NUM_CORES = 4,
  parameter int PKT_W = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CORES-1:0]       core_pkt_valid,
  input  logic [NUM_CORES*PKT_W-1:0] core_pkt_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_W+PKT_W-1:0]      out_data,
  input  logic                       clr_stat,
  output logic [NUM_CORES-1:0]       overflow,
  output logic                       busy
`ifdef SPIKE_COLLECTOR_DROP_CNT_EN
  , output logic [NUM_CORES*CNT_W-1:0] drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [NUM_CORES-1:0] w_ne, w_pop;
  logic [PKT_W-1:0] w_head [NUM_CORES];
  logic w_load, w_gnt_v;
  logic [ID_W-1:0] w_gnt, r_last;
  logic [PKT_W-1:0] w_gnt_pkt;
  logic r_out_valid;
  logic [ID_W+PKT_W-1:0] r_out_data;
  assign w_load = ~r_out_valid | out_ready;
  assign busy = |w_ne | r_out_valid;
  assign out_valid = r_out_valid;
  assign out_data = r_out_data;
  // Offsets are scanned farthest-first so the nearest non-empty channel after r_last wins.
  always_comb begin
    w_gnt = '0;
    w_gnt_v = 1'b0;
    w_gnt_pkt = '0;
    for (int k = NUM_CORES; k >= 1; k--)
      for (int j = 0; j < NUM_CORES; j++)
        if (w_ne[j] && j == (int'(r_last) + k) % NUM_CORES) begin
          w_gnt = ID_W'(j);
          w_gnt_v = 1'b1;
          w_gnt_pkt = w_head[j];
        end
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_last <= ID_W'(NUM_CORES - 1);
    end else if (w_load) begin
      r_out_valid <= w_gnt_v;
      if (w_gnt_v) begin
        r_out_data <= {w_gnt, w_gnt_pkt};
        r_last <= w_gnt;
      end
    end
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_ch
    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0] r_cnt;
    logic r_ovf;
    logic w_full, w_push, w_drop;
    assign w_full = r_cnt == (AW+1)'(DEPTH);
    assign w_ne[i] = r_cnt != '0;
    assign w_pop[i] = w_load & w_gnt_v & (w_gnt == ID_W'(i));
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_push = core_pkt_valid[i] & (~w_full | w_pop[i]);
    assign w_drop = core_pkt_valid[i] & w_full & ~w_pop[i];
    assign w_head[i] = r_mem[r_rd];
    assign overflow[i] = r_ovf;
    always_ff @(posedge clk)
      if (w_push) r_mem[r_wr] <= core_pkt_data[i*PKT_W +: PKT_W];
    always_ff @(posedge clk)
      if (reset) begin
        r_rd <= '0;
        r_wr <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_rd <= r_rd + AW'(w_pop[i]);
        r_wr <= r_wr + AW'(w_push);
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop[i]);
        r_ovf <= (clr_stat ? 1'b0 : r_ovf) | w_drop;
      end
`ifdef SPIKE_COLLECTOR_DROP_CNT_EN
    logic [CNT_W-1:0] r_dcnt;
    always_ff @(posedge clk)
      if (reset) r_dcnt <= '0;
      else if (clr_stat) r_dcnt <= CNT_W'(w_drop);
      else if (w_drop & ~&r_dcnt) r_dcnt <= r_dcnt + 1'b1;
    assign drop_cnt[i*CNT_W +: CNT_W] = r_dcnt;
`endif
  end
`ifndef SPIKE_COLLECTOR_DROP_CNT_EN
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif
endmodule

// File: tb/tb_snn_spike_collector.sv
// tb_snn_spike_collector: vector table, corner-case sequences and random traffic against a queue-based model.
module tb_snn_spike_collector;
  logic clk = 1'b0, reset = 1'b1, out_ready = 1'b0, clr_stat = 1'b0;
  logic [3:0] core_pkt_valid = '0;
  logic [31:0] core_pkt_data = '0;
  logic out_valid, busy;
  logic [9:0] out_data;
  logic [3:0] overflow;
`ifdef SPIKE_COLLECTOR_DROP_CNT_EN
  logic [63:0] drop_cnt;
`endif
  int n_vec = 0, n_err = 0;
  localparam int MAXC = 65535;
  logic [7:0] q [4][$];
  logic mv;
  logic [9:0] md;
  int last;
  logic [3:0] movf;
  int mdc [4];
  typedef struct {
    logic rst;
    logic [3:0] v;
    logic [31:0] d;
    logic rdy;
    logic ev;
    logic [9:0] ed;
    logic eb;
  } vec_t;
  vec_t tbl [17];

  snn_spike_collector dut (
    .clk(clk),
    .reset(reset),
    .core_pkt_valid(core_pkt_valid),
    .core_pkt_data(core_pkt_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .clr_stat(clr_stat),
    .overflow(overflow),
    .busy(busy)
`ifdef SPIKE_COLLECTOR_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one queue per core, a one-word output register, round-robin search by plain arithmetic.
  task automatic model(input logic [3:0] v, input logic [31:0] d, input logic rdy, input logic clr, input logic rst);
    int g;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        mdc[i] = 0;
      end
      mv = 1'b0;
      md = '0;
      last = 3;
      movf = '0;
      return;
    end
    if (!mv || rdy) begin
      g = -1;
      for (int k = 1; k <= 4; k++)
        if (g < 0 && q[(last + k) % 4].size() > 0) g = (last + k) % 4;
      if (g >= 0) begin
        md = {g[1:0], q[g].pop_front()};
        mv = 1'b1;
        last = g;
      end else mv = 1'b0;
    end
    if (clr) begin
      movf = '0;
      for (int i = 0; i < 4; i++) mdc[i] = 0;
    end
    for (int i = 0; i < 4; i++)
      if (v[i]) begin
        if (q[i].size() < 16) q[i].push_back(d[i*8 +: 8]);
        else begin
          movf[i] = 1'b1;
          if (mdc[i] < MAXC) mdc[i]++;
        end
      end
  endtask

  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic rdy, input logic clr, input logic rst);
    logic mb;
    @(negedge clk);
    core_pkt_valid = v;
    core_pkt_data = d;
    out_ready = rdy;
    clr_stat = clr;
    reset = rst;
    model(v, d, rdy, clr, rst);
    @(posedge clk);
    #1;
    mb = mv;
    for (int i = 0; i < 4; i++) if (q[i].size() > 0) mb = 1'b1;
    chk("model_out_valid", out_valid, mv);
    if (mv) chk("model_out_data", out_data, md);
    chk("model_busy", busy, mb);
    chk("model_overflow", overflow, movf);
`ifdef SPIKE_COLLECTOR_DROP_CNT_EN
    for (int i = 0; i < 4; i++) chk("model_drop_cnt", drop_cnt[i*16 +: 16], 64'(mdc[i]));
`endif
  endtask

  initial begin
    logic [3:0] v;
    logic rdy;
    int words;
    logic [9:0] last_w;
    tbl[0]  = '{1'b1, 4'h0, 32'h0,        1'b1, 1'b0, 10'h000, 1'b0};
    tbl[1]  = '{1'b0, 4'h4, 32'h00A50000, 1'b1, 1'b0, 10'h000, 1'b1};
    tbl[2]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 10'h2A5, 1'b1};
    tbl[3]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 10'h000, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 32'h0,        1'b1, 1'b0, 10'h000, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 1'b0, 10'h000, 1'b1};
    tbl[6]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 10'h010, 1'b1};
    tbl[7]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 10'h111, 1'b1};
    tbl[8]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 10'h212, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 10'h313, 1'b1};
    tbl[10] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 10'h000, 1'b0};
    tbl[11] = '{1'b0, 4'hF, 32'h23222120, 1'b1, 1'b0, 10'h000, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 10'h020, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 10'h121, 1'b1};
    tbl[14] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 10'h222, 1'b1};
    tbl[15] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 10'h323, 1'b1};
    tbl[16] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 10'h000, 1'b0};
    for (int r = 0; r < 17; r++) begin
      step(tbl[r].v, tbl[r].d, tbl[r].rdy, 1'b0, tbl[r].rst);
      chk("tbl_out_valid", out_valid, tbl[r].ev);
      if (tbl[r].ev) chk("tbl_out_data", out_data, tbl[r].ed);
      chk("tbl_busy", busy, tbl[r].eb);
      if (r == 0) begin
        chk("reset_out_data", out_data, 10'h0);
        chk("reset_overflow", overflow, 4'h0);
      end
    end
    // Backpressure: core 1 fills FIFO plus output stage, then one more packet is lost.
    step(4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 17; n++) step(4'h2, {16'h0, 8'(128 + n), 8'h0}, 1'b0, 1'b0, 1'b0);
    step(4'h2, 32'h0000FF00, 1'b0, 1'b0, 1'b0);
    chk("bp_overflow", overflow, 4'b0010);
`ifdef SPIKE_COLLECTOR_DROP_CNT_EN
    chk("bp_drop_cnt1", drop_cnt[31:16], 64'd1);
`endif
    words = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) begin
        chk("bp_word", out_data, {2'd1, 8'(128 + words)});
        words++;
      end
      step(4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("bp_word_count", 64'(words), 64'd17);
    // Full FIFO with simultaneous pop and push: nothing lost.
    step(4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 17; n++) step(4'h1, {24'h0, 8'(64 + n)}, 1'b0, 1'b0, 1'b0);
    step(4'h1, 32'h00000077, 1'b1, 1'b0, 1'b0);
    chk("pp_overflow", overflow, 4'h0);
    last_w = '0;
    for (int c = 0; c < 20; c++) begin
      step(4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      if (out_valid) last_w = out_data;
    end
    chk("pp_last_word", last_w, 10'h077);
    // Stat clear coinciding with a drop on core 3.
    step(4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 22; n++) step(4'h8, {8'(n), 24'h0}, 1'b0, 1'b0, 1'b0);
`ifdef SPIKE_COLLECTOR_DROP_CNT_EN
    chk("clr_pre_drop_cnt3", drop_cnt[63:48], 64'd5);
`endif
    step(4'h8, 32'hEE000000, 1'b0, 1'b1, 1'b0);
    chk("clr_overflow", overflow, 4'b1000);
`ifdef SPIKE_COLLECTOR_DROP_CNT_EN
    chk("clr_drop_cnt3", drop_cnt[63:48], 64'd1);
`endif
    // Reset while words are buffered and the output is held.
    step(4'h7, 32'h00030201, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_valid", out_valid, 1'b1);
    step(4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 4'h0);
    step(4'h2, 32'h00003C00, 1'b1, 1'b0, 1'b0);
    step(4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("rst_fresh_valid", out_valid, 1'b1);
    chk("rst_fresh_data", out_data, 10'h13C);
    // Random traffic: light then heavy backpressure.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) v[i] = $urandom_range(0, 9) < 3;
      rdy = $urandom_range(0, 99) < (n < 750 ? 80 : 20);
      step(v, $urandom, rdy, $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
